fifo_stream_reader: RTL and testbench

//  Read-side consumer for the 16-deep FIFO. Issues fifo_rd, absorbs the FIFO's
//  1-cycle registered read latency, and presents words on a valid/ready stream
//  via a 2-entry output buffer. Sits between the FIFO and any downstream sink.

---
 rtl/fifo_stream_reader.sv | 108 ++++++++++
 tb/tb_fifo_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side consumer for a FIFO with a one-cycle registered read latency.
// Issues fifo_rd, catches the returning word one cycle later, and presents
// words on a valid/ready stream through a two-entry output buffer. With the
// sink always ready it sustains one word per cycle.
//
// Ports
//   clk         in   1     clock, rising edge
//   rst         in   1     asynchronous, active-high reset
//   flush       in   1     synchronous clear of buffer and in-flight read
//   fifo_empty  in   1     FIFO empty flag (updates with the read pointer)
//   fifo_dout   in   DW    FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  1     FIFO read strobe (combinational)
//   m_valid     out  1     output word valid
//   m_data      out  DW    output word (buffer head)
//   m_ready     in   1     sink ready
//   rd_count    out  CNTW  words delivered, wraps at 2^CNTW
//   busy        out  1     buffer non-empty or a read is in flight
//
// Handshake: a word transfers on every rising edge where m_valid && m_ready.
// m_valid never depends on m_ready, and while m_valid && !m_ready the word on
// m_data is held unchanged until it is accepted (or flush/rst discards it).
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            fifo_empty,
    input  logic [DW-1:0]   fifo_dout,
    output logic            fifo_rd,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    input  logic            m_ready,
    output logic [CNTW-1:0] rd_count,
    output logic            busy
);

    // Buffer state: occupancy 0..2, head pointer, and two storage slots.
    logic [1:0]    occ;
    logic          pend;
    logic          hd;
    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;

    logic          pop;
    logic [2:0]    after_pop;
    logic          wr_slot;

    assign m_valid = (occ != 2'd0);
    assign m_data  = hd ? slot1 : slot0;
    assign busy    = (occ != 2'd0) || pend;
    assign pop     = m_valid && m_ready;

    // Words the buffer will hold after this edge, counting the in-flight read
    // as already landed. A new read is only safe if that leaves room for one
    // more word next cycle, so the buffer can never overfill. Since pop
    // implies occ >= 1 this never goes negative.
    assign after_pop = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    assign fifo_rd = !rst && !flush && !fifo_empty && (after_pop <= 3'd1);

    // Capture slot is the first free slot behind the head: (hd + occ) % 2.
    // A capture only happens with occ <= 1, so this never hits a live head.
    assign wr_slot = hd ^ occ[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            pend     <= 1'b0;
            hd       <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
            rd_count <= '0;
        end else begin
            // fifo_rd is forced low during flush, so pend clears with it.
            pend <= fifo_rd;

            // A pop in the flush cycle was a real handshake and still counts.
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end

            if (flush) begin
                // The word returning from an in-flight read is dropped here.
                occ <= 2'd0;
                hd  <= 1'b0;
            end else begin
                occ <= after_pop[1:0];
                if (pend) begin
                    if (wr_slot) begin
                        slot1 <= fifo_dout;
                    end else begin
                        slot0 <= fifo_dout;
                    end
                end
                if (pop) begin
                    hd <= ~hd;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader. A behavioural 16-deep FIFO with registered
// read data feeds the DUT. Every word pushed into the FIFO is also pushed into
// an expected queue; a monitor on the falling edge pops and compares on each
// handshake. Words the DUT held when a flush or reset hit are removed from the
// front of the expected queue (the FIFO has already given them up).
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW   = 16;
    localparam int CNTW = 8;

    // ---------------- clock / reset ----------------
    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            flush      = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [DW-1:0]   fifo_dout  = '0;
    logic            m_ready    = 1'b0;
    logic            fifo_rd;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [CNTW-1:0] rd_count;
    logic            busy;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    // ---------------- model state ----------------
    logic [DW-1:0]   fifo_mem[$];   // contents of the behavioural FIFO
    logic [DW-1:0]   exp_q[$];      // words still owed to the sink, in order
    int              taken     = 0; // words the FIFO has handed to the DUT
    int              consumed  = 0; // words delivered or discarded
    int              delivered = 0; // words delivered by handshake
    logic [CNTW-1:0] exp_count = '0;
    logic            rd_seen   = 1'b0;
    logic            stall_prev = 1'b0;
    logic [DW-1:0]   stall_data = '0;
    logic            flush_prev = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural FIFO ----------------
    // Read request is sampled on the falling edge; the word leaves the FIFO on
    // the following rising edge and the empty flag moves on that same edge.
    always @(posedge clk) begin
        if (rd_seen && fifo_mem.size() > 0) begin
            fifo_dout <= fifo_mem.pop_front();
            taken++;
        end
        fifo_empty <= (fifo_mem.size() == 0);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        rd_seen = fifo_rd;
        if (!rst) begin
            if (fifo_empty) check("rd_when_empty", 32'(fifo_rd), 32'd0);
            if (flush)      check("rd_during_flush", 32'(fifo_rd), 32'd0);
            if (flush_prev) check("valid_after_flush", 32'(m_valid), 32'd0);
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(stall_data));
            end
            check("held_le_2", 32'((taken - consumed) <= 2), 32'd1);
            check("busy", 32'(busy), 32'((taken - consumed) != 0));
            check("rd_count", 32'(rd_count), 32'(exp_count));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", m_data);
                end else begin
                    check("data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                consumed++;
                delivered++;
                exp_count++;
            end
            if (flush) begin
                while (consumed < taken && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
            end
            stall_prev = m_valid && !m_ready && !flush;
            stall_data = m_data;
            flush_prev = flush;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        int n = 0;
        while (fifo_mem.size() >= 16 && n < 1000) begin
            step();
            n++;
        end
        check("push_space", 32'(n < 1000), 32'd1);
        fifo_mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && fifo_mem.size() == 0 && !busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        while (consumed < taken && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            consumed++;
        end
        exp_count  = '0;
        stall_prev = 1'b0;
        flush_prev = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int nrd;
        int npop;
        int base_delivered;
        logic [CNTW-1:0] base_count;
        int pushed;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_fifo_rd", 32'(fifo_rd), 32'd0);
        check("reset_rd_count", 32'(rd_count), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: four words, sink always ready: back-to-back reads, 2-cycle latency
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd && n < 20);
        check("t1_first_rd", 32'(n < 20), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("t1_rd_pattern", 32'(fifo_rd), 32'(k < 4));
            check("t1_valid_pattern", 32'(m_valid), 32'(k >= 2 && k < 6));
            if (k >= 2 && k < 6) check("t1_data", 32'(m_data), 32'(k - 1));
            if (k == 6) check("t1_rd_count", 32'(rd_count), 32'd4);
            @(negedge clk);
        end
        wait_idle();

        // 2: sink stalled, five words: only two reads, head held
        step();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        nrd = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_rd) nrd++;
        end
        check("t2_reads", 32'(nrd), 32'd2);
        check("t2_valid", 32'(m_valid), 32'd1);
        check("t2_head", 32'(m_data), 32'h0001);
        step();
        m_ready = 1'b1;
        wait_idle();

        // 3: single word, then empty: exactly one read and one handshake
        step();
        push_word(16'hBEEF);
        nrd  = 0;
        npop = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_rd) nrd++;
            if (m_valid && m_ready) npop++;
        end
        check("t3_reads", 32'(nrd), 32'd1);
        check("t3_pops", 32'(npop), 32'd1);
        check("t3_empty", 32'(fifo_empty), 32'd1);
        check("t3_no_rd", 32'(fifo_rd), 32'd0);

        // 4: flush with 0x0011 buffered and 0x00AA in flight
        step();
        m_ready = 1'b0;
        push_word(16'h0011);
        wait_valid();
        step();
        push_word(16'h00AA);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd && n < 20);
        check("t4_rd_aa", 32'(n < 20), 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("t4_pend_busy", 32'(busy), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t4_valid_cleared", 32'(m_valid), 32'd0);
        check("t4_busy_cleared", 32'(busy), 32'd0);
        step();
        push_word(16'h0077);
        m_ready = 1'b1;
        wait_idle();

        // 5: reset mid-stream, then resume from the FIFO's current word
        step();
        for (int i = 0; i < 8; i++) push_word(16'h0500 + 16'(i));
        wait_valid();
        pulse_reset();
        wait_idle();

        // 6: 1000 random words with a random sink
        step();
        base_delivered = delivered;
        base_count     = exp_count;
        pushed         = 0;
        n              = 0;
        while (pushed < 1000 && n < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && fifo_mem.size() < 16) begin
                fifo_mem.push_back(16'($urandom));
                exp_q.push_back(fifo_mem[fifo_mem.size() - 1]);
                pushed++;
            end
            step();
            n++;
        end
        check("t6_push_budget", 32'(pushed), 32'd1000);
        while (exp_q.size() > 0 && n < 30000) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("t6_delivered", 32'(delivered - base_delivered), 32'd1000);
        check("t6_rd_count", 32'(rd_count), 32'(CNTW'(base_count + CNTW'(1000))));
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
